perf_host_mc: RTL and testbench
===============================

# perf_host_mc

Parametrised multi-channel host-stream performance block, instantiated inside a vFPGA user-logic region. It is driven by host software over the AXI4-Lite control interface. Per channel it loops host streams back, sinks them, or generates them, over N_CHAN parallel AXI4SR channel pairs. Per-channel beat and cycle counters give throughput measurements.

## Interface
- N_CHAN, 2: number of host stream channel pairs (1..4).
- PKT_BEATS, 64: generator packet length in beats (power of two, 1..4096).
- CNT_BITS, 32: width of the per-channel beat and cycle counters (≤ 64).
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- axi_ctrl  AXI4L.s  64-bit data, 64-bit address  register interface.
- axis_host_sink[N_CHAN]  AXI4SR.s  512-bit tdata  host→FPGA streams.
- axis_host_src[N_CHAN]  AXI4SR.m  512-bit tdata  FPGA→host streams.

## Operation
- Register map (64-bit words):
  - 0x00 CTRL (W): bit0 START (self-clearing pulse), bit1 CLEAR (pulse), bits[3:2] MODE.
  - 0x08 LEN (RW): target beats per channel.
  - 0x10 CHAN_EN (RW): bits[N_CHAN-1:0] channel enable mask.
  - 0x18 STATUS (R): bit0 BUSY, bit1 DONE, bits[8+N_CHAN-1:8] per-channel complete.
  - 0x20+0x10*c BEATS[c] (R); 0x28+0x10*c CYCLES[c] (R).
  - Unmapped reads return 0; unmapped writes are dropped; all responses are OKAY.
- MODE values:
  - 0 loopback: sink→src combinational; tdata/tkeep/tlast/tid pass through; sink.tready = src.tready.
  - 1 sink-only: sink.tready = 1; src.tvalid = 0.
  - 2 source-only: generator; sink.tready = 0.
  - 3 reserved: START is ignored.
- FSM states IDLE, RUN, DONE:
  - IDLE→RUN on START when MODE≠3, LEN≠0 and CHAN_EN≠0. Entry zeroes all counters and latches MODE, LEN and CHAN_EN.
  - RUN→DONE when every enabled channel is complete.
  - DONE→RUN on START; counters are re-zeroed and the new configuration is latched.
  - CLEAR in any state forces IDLE and zeroes all counters. CLEAR wins over START in the same write.
  - START while in RUN is ignored.
- A channel is active when it is in RUN, enabled and not yet complete.
  - Only an active channel asserts tready/tvalid; inactive channels drive both low.
- BEATS[c]:
  - Modes 0/1: +1 per sink handshake.
  - Mode 2: +1 per src handshake.
  - Channel c is complete when BEATS[c] == LEN; it then stops and stays stalled.
- CYCLES[c]: +1 every cycle channel c is active, counted from the RUN entry cycle through the cycle of its final beat inclusive.
- Generator:
  - tdata = BEATS[c] zero-extended to 64 bits, replicated 8×.
  - tkeep = all ones; tid = c.
  - tlast when (BEATS[c]+1) mod PKT_BEATS == 0 or BEATS[c]+1 == LEN.
- Counters saturate at all-ones.
- In mode 0, tlast is passed through unmodified and does not end the run; completion is by beat count only.

## Timing
- Reset values:
  - FSM IDLE; all counters, LEN, CHAN_EN, MODE = 0.
  - All src tvalid = 0 and all sink tready = 0.
  - awready = wready = arready = 0; bvalid = rvalid = 0.
- AXI4-Lite:
  - Write: awready and wready assert together only when both awvalid and wvalid are high and bvalid is low. bvalid rises the next cycle and holds until bready.
  - Read: arready asserts when rvalid is low. rvalid/rdata follow one cycle after the arvalid & arready handshake and hold until rready.
- A START write is effective the cycle after the write handshake: RUN is entered then, and streams may handshake that same cycle.
- Data path latency: loopback 0 cycles; generator issues one beat per cycle with tvalid, tdata and tlast registered.
- Generator backpressure: with tvalid high and tready low, tdata and tlast are held stable.
- Completion: the beat handshake with BEATS+1 == LEN deasserts that channel's tvalid/tready in the following cycle. DONE is reached one cycle after the last channel completes.
- STATUS reads reflect the state registered at the cycle of the read handshake.
- Reset asserted mid-run clears everything immediately. An in-flight AXI-Lite transaction is abandoned.

## Test plan
- Loopback: MODE=0, LEN=100, CHAN_EN=0b11, both sinks driven continuously with src.tready=1 -> 100 beats pass through on each channel with tdata identical; BEATS=100, CYCLES=100, DONE=1.
- Sink-only with 50% random sink tvalid, LEN=256 -> BEATS[0]=256; CYCLES[0] equals the cycle count from RUN to the last beat; sink.tready=0 after completion.
- Generator: MODE=2, LEN=130, PKT_BEATS=64, src.tready toggling -> tdata word sequence 0..129, tlast on beats 63, 127 and 129; data held stable while stalled.
- Partial mask: CHAN_EN=0b10, N_CHAN=2 -> channel 0 tvalid/tready stay 0; DONE is driven by channel 1 only; BEATS[0]=0.
- CLEAR mid-RUN after 40 beats -> next cycle IDLE; BEATS=0; streams stalled; a subsequent START reruns a full LEN.
- Edge cases:
  - START with LEN=0 or MODE=3 -> remains IDLE.
  - areset pulse during RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/perf_host_mc.sv
// perf_host_mc: per-channel host stream loopback / sink / generator with beat and cycle counters.
// Ports: i_aclk, i_areset (async, active high); AXI4-Lite slave i_aw*/i_w*/o_b*/i_ar*/o_r* (64-bit);
//        N_CHAN sink streams i_sink_* / o_sink_tready and source streams o_src_* / i_src_tready (512-bit).
module perf_host_mc #(
  parameter int N_CHAN    = 2,
  parameter int PKT_BEATS = 64,
  parameter int CNT_BITS  = 32
) (
  input  logic                     i_aclk,
  input  logic                     i_areset,
  input  logic [63:0]              i_awaddr,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [63:0]              i_wdata,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  output logic [1:0]               o_bresp,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  input  logic [63:0]              i_araddr,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  output logic [63:0]              o_rdata,
  output logic [1:0]               o_rresp,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  input  logic [N_CHAN-1:0][511:0] i_sink_tdata,
  input  logic [N_CHAN-1:0][63:0]  i_sink_tkeep,
  input  logic [N_CHAN-1:0]        i_sink_tlast,
  input  logic [N_CHAN-1:0][5:0]   i_sink_tid,
  input  logic [N_CHAN-1:0]        i_sink_tvalid,
  output logic [N_CHAN-1:0]        o_sink_tready,
  output logic [N_CHAN-1:0][511:0] o_src_tdata,
  output logic [N_CHAN-1:0][63:0]  o_src_tkeep,
  output logic [N_CHAN-1:0]        o_src_tlast,
  output logic [N_CHAN-1:0][5:0]   o_src_tid,
  output logic [N_CHAN-1:0]        o_src_tvalid,
  input  logic [N_CHAN-1:0]        i_src_tready
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [63:0] r_len, r_run_len, r_rdata, w_rdata;
  logic [N_CHAN-1:0] r_en, r_run_en, w_cmp, w_act, w_hs;
  logic [1:0] r_run_mode;
  logic [N_CHAN-1:0][CNT_BITS-1:0] r_beats, r_cycles, w_nxt;
  logic r_bvalid, r_rvalid, w_wr, w_rd, w_ctrl, w_clear, w_start, w_enter, w_all;
  assign o_awready = i_awvalid & i_wvalid & ~r_bvalid & ~i_areset;
  assign o_wready  = o_awready;
  assign o_arready = ~r_rvalid & ~i_areset;
  assign o_bvalid  = r_bvalid;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_bresp   = 2'b00;
  assign o_rresp   = 2'b00;
  assign w_wr    = o_awready;
  assign w_rd    = i_arvalid & o_arready;
  assign w_ctrl  = w_wr && i_awaddr == 64'h0;
  assign w_clear = w_ctrl & i_wdata[1];
  assign w_start = w_ctrl & i_wdata[0] & (i_wdata[3:2] != 2'd3) & (r_len != 64'd0) & (|r_en) & (r_state != S_RUN);
  assign w_enter = w_start & ~w_clear;
  assign w_all   = &(w_cmp | ~r_run_en);
  always_comb begin
    w_next = r_state;
    if (w_clear) w_next = S_IDLE;
    else if (w_enter) w_next = S_RUN;
    else if (r_state == S_RUN && w_all) w_next = S_DONE;
  end
  always_ff @(posedge i_aclk or posedge i_areset)
    if (i_areset) r_state <= S_IDLE;
    else r_state <= w_next;
  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    assign w_nxt[c] = r_beats[c] + CNT_BITS'(1);
    assign w_cmp[c] = r_state != S_IDLE && r_run_en[c] && 64'(r_beats[c]) == r_run_len;
    assign w_act[c] = r_state == S_RUN && r_run_en[c] && !w_cmp[c];
    assign w_hs[c]  = r_run_mode == 2'd2 ? o_src_tvalid[c] & i_src_tready[c] : i_sink_tvalid[c] & o_sink_tready[c];
    assign o_sink_tready[c] = w_act[c] & (r_run_mode == 2'd0 ? i_src_tready[c] : r_run_mode == 2'd1);
    assign o_src_tvalid[c]  = w_act[c] & (r_run_mode == 2'd0 ? i_sink_tvalid[c] : r_run_mode == 2'd2);
    // Generator outputs derive only from registered state, so they hold while stalled.
    assign o_src_tdata[c] = r_run_mode == 2'd2 ? {8{64'(r_beats[c])}} : i_sink_tdata[c];
    assign o_src_tkeep[c] = r_run_mode == 2'd2 ? 64'hFFFF_FFFF_FFFF_FFFF : i_sink_tkeep[c];
    assign o_src_tid[c]   = r_run_mode == 2'd2 ? 6'(c) : i_sink_tid[c];
    assign o_src_tlast[c] = r_run_mode == 2'd2 ?
      ((w_nxt[c] & CNT_BITS'(PKT_BEATS - 1)) == '0 || 64'(w_nxt[c]) == r_run_len) : i_sink_tlast[c];
  end
  always_ff @(posedge i_aclk or posedge i_areset)
    if (i_areset) begin
      r_beats  <= '0;
      r_cycles <= '0;
    end else if (w_clear || w_enter) begin
      r_beats  <= '0;
      r_cycles <= '0;
    end else begin
      for (int c = 0; c < N_CHAN; c++)
        if (w_act[c]) begin
          r_cycles[c] <= &r_cycles[c] ? r_cycles[c] : r_cycles[c] + CNT_BITS'(1);
          if (w_hs[c]) r_beats[c] <= &r_beats[c] ? r_beats[c] : w_nxt[c];
        end
    end
  always_ff @(posedge i_aclk or posedge i_areset)
    if (i_areset) begin
      r_len      <= '0;
      r_en       <= '0;
      r_run_len  <= '0;
      r_run_en   <= '0;
      r_run_mode <= '0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_wr && i_awaddr == 64'h8) r_len <= i_wdata;
      if (w_wr && i_awaddr == 64'h10) r_en <= i_wdata[N_CHAN-1:0];
      if (w_enter) begin
        r_run_len  <= r_len;
        r_run_en   <= r_en;
        r_run_mode <= i_wdata[3:2];
      end
      r_bvalid <= w_wr | (r_bvalid & ~i_bready);
      r_rvalid <= w_rd | (r_rvalid & ~i_rready);
      if (w_rd) r_rdata <= w_rdata;
    end
  always_comb begin
    w_rdata = '0;
    if (i_araddr == 64'h8) w_rdata = r_len;
    if (i_araddr == 64'h10) w_rdata = 64'(r_en);
    if (i_araddr == 64'h18) w_rdata = 64'({w_cmp, 6'd0, r_state == S_DONE, r_state == S_RUN});
    for (int c = 0; c < N_CHAN; c++) begin
      if (i_araddr == 64'(32 + 16 * c)) w_rdata = 64'(r_beats[c]);
      if (i_araddr == 64'(40 + 16 * c)) w_rdata = 64'(r_cycles[c]);
    end
  end
endmodule

// File: tb/tb_perf_host_mc.sv
// tb_perf_host_mc: self-checking bench for perf_host_mc
module tb_perf_host_mc;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [63:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [N-1:0][511:0] sk_data = '0, sr_data;
  logic [N-1:0][63:0] sk_keep = '1, sr_keep;
  logic [N-1:0] sk_last = '0, sk_valid = '0, sk_ready, sr_last, sr_valid, sr_ready = '0;
  logic [N-1:0][5:0] sk_id, sr_id;
  perf_host_mc #(.N_CHAN(N), .PKT_BEATS(64), .CNT_BITS(32)) dut (
    .i_aclk(clk), .i_areset(rst),
    .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready),
    .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
    .i_sink_tdata(sk_data), .i_sink_tkeep(sk_keep), .i_sink_tlast(sk_last), .i_sink_tid(sk_id),
    .i_sink_tvalid(sk_valid), .o_sink_tready(sk_ready),
    .o_src_tdata(sr_data), .o_src_tkeep(sr_keep), .o_src_tlast(sr_last), .o_src_tid(sr_id),
    .o_src_tvalid(sr_valid), .i_src_tready(sr_ready)
  );
  int checks = 0, failures = 0;
  int tb_mode = 0, tb_state = 0, tb_pct = 0, tb_rpct = 100;
  logic [63:0] tb_len = '0, tb_rlen = '0;
  logic [N-1:0] tb_en = '0, tb_ren = '0, tb_act = '0, tb_drv = '0, acc = '0;
  int tb_beats[N], tb_cyc[N];
  logic [64:0] sb[N][$];
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;
  vec_t vt[20];
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic zero_model();
    for (int c = 0; c < N; c++) begin
      tb_beats[c] = 0;
      tb_cyc[c] = 0;
    end
  endtask
  task automatic flush();
    for (int c = 0; c < N; c++) sb[c].delete();
  endtask
  function automatic logic [63:0] status_exp();
    logic [63:0] s = '0;
    s[0] = tb_state == 1;
    s[1] = tb_state == 2;
    if (tb_state != 0) s[8 +: N] = tb_ren & ~tb_act;
    return s;
  endfunction
  function automatic logic gen_last(input int i, input int len);
    return ((i + 1) % 64 == 0) || (i + 1 == len);
  endfunction
  task automatic axi_write(input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    step();
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("awready", awready, 1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    if (a == 64'h0) begin
      if (d[1]) begin
        tb_act = '0; tb_state = 0; zero_model();
      end else if (d[0] && d[3:2] != 2'd3 && tb_len != 0 && tb_en != 0 && tb_state != 1) begin
        tb_rlen = tb_len; tb_ren = tb_en; tb_act = tb_en; tb_state = 1; zero_model();
      end
    end
    if (a == 64'h8) tb_len = d;
    if (a == 64'h10) tb_en = d[N-1:0];
    @(negedge clk);
    chk("bvalid", bvalid, 1);
  endtask
  task automatic axi_read(input logic [63:0] a, output logic [63:0] d);
    int n = 0;
    step();
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arready", arready, 1);
    step();
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", rvalid, 1);
    d = rdata;
  endtask
  task automatic rd_chk(input string name, input logic [63:0] a, input logic [63:0] exp);
    logic [63:0] d;
    axi_read(a, d);
    chk(name, d, exp);
  endtask
  task automatic wait_run(input int lim);
    int n = 0;
    while (tb_act != 0 && n < lim) begin @(negedge clk); n++; end
    chk("run_timeout", tb_act, 0);
    repeat (4) @(negedge clk);
  endtask
  always @(negedge clk) begin
    logic hs, etr, etv;
    for (int c = 0; c < N; c++) begin
      etr = tb_act[c] & (tb_mode == 0 ? sr_ready[c] : tb_mode == 1);
      etv = tb_act[c] & (tb_mode == 0 ? sk_valid[c] : tb_mode == 2);
      chk("sink_tready", sk_ready[c], etr);
      chk("src_tvalid", sr_valid[c], etv);
      acc[c] = sk_valid[c] & sk_ready[c];
      if (sr_valid[c] && tb_mode != 1) begin
        chk("sb_nonempty", sb[c].size() != 0, 1);
        if (sb[c].size() != 0) begin
          chk("src_tdata", sr_data[c], {8{sb[c][0][63:0]}});
          chk("src_tlast", sr_last[c], sb[c][0][64]);
          chk("src_tkeep", sr_keep[c], 64'hFFFF_FFFF_FFFF_FFFF);
          chk("src_tid", sr_id[c], 6'(c));
        end
      end
      hs = tb_mode == 2 ? etv & sr_ready[c] : etr & sk_valid[c];
      if (hs && tb_mode != 1 && sb[c].size() != 0) void'(sb[c].pop_front());
      if (tb_act[c]) begin
        tb_cyc[c]++;
        if (hs) tb_beats[c]++;
        if (64'(tb_beats[c]) == tb_rlen) tb_act[c] = 1'b0;
      end
    end
    if (tb_state == 1 && tb_act == 0) tb_state = 2;
  end
  initial begin
    logic [63:0] w;
    logic l;
    forever begin
      step();
      for (int c = 0; c < N; c++) begin
        sr_ready[c] = $urandom_range(99) < tb_rpct;
        if (!tb_drv[c]) sk_valid[c] = 1'b0;
        else if (!sk_valid[c] || acc[c]) begin
          sk_valid[c] = $urandom_range(99) < tb_pct;
          if (sk_valid[c]) begin
            w = {$urandom, $urandom};
            l = 1'($urandom_range(1));
            sk_data[c] = {8{w}};
            sk_last[c] = l;
            if (tb_mode == 0) sb[c].push_back({l, w});
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int c = 0; c < N; c++) sk_id[c] = 6'(c);
    zero_model();
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_src_tvalid", sr_valid, 0);
    chk("rst_sink_tready", sk_ready, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vt[0]  = '{1'b0, 64'h8,    64'h0, 64'h0};
    vt[1]  = '{1'b0, 64'h10,   64'h0, 64'h0};
    vt[2]  = '{1'b0, 64'h18,   64'h0, 64'h0};
    vt[3]  = '{1'b0, 64'h20,   64'h0, 64'h0};
    vt[4]  = '{1'b0, 64'h38,   64'h0, 64'h0};
    vt[5]  = '{1'b1, 64'h8,    64'h1234_5678_9ABC_DEF0, 64'h0};
    vt[6]  = '{1'b0, 64'h8,    64'h0, 64'h1234_5678_9ABC_DEF0};
    vt[7]  = '{1'b1, 64'h10,   64'hFF, 64'h0};
    vt[8]  = '{1'b0, 64'h10,   64'h0, 64'h3};
    vt[9]  = '{1'b1, 64'h40,   64'h55, 64'h0};
    vt[10] = '{1'b0, 64'h40,   64'h0, 64'h0};
    vt[11] = '{1'b0, 64'h0,    64'h0, 64'h0};
    vt[12] = '{1'b0, 64'h1000, 64'h0, 64'h0};
    vt[13] = '{1'b1, 64'h8,    64'h0, 64'h0};
    vt[14] = '{1'b1, 64'h0,    64'h1, 64'h0};
    vt[15] = '{1'b0, 64'h18,   64'h0, 64'h0};
    vt[16] = '{1'b1, 64'h8,    64'd10, 64'h0};
    vt[17] = '{1'b1, 64'h0,    64'hD, 64'h0};
    vt[18] = '{1'b1, 64'h0,    64'h3, 64'h0};
    vt[19] = '{1'b0, 64'h18,   64'h0, 64'h0};
    for (int i = 0; i < 20; i++)
      if (vt[i].wr) axi_write(vt[i].addr, vt[i].data);
      else rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
    // loopback, both channels, continuous traffic
    tb_mode = 0; tb_pct = 100; tb_rpct = 100;
    axi_write(64'h8, 64'd100);
    axi_write(64'h10, 64'h3);
    tb_drv = 2'b11;
    axi_write(64'h0, 64'h1);
    wait_run(1000);
    tb_drv = '0; step(); step(); flush();
    rd_chk("lb_beats0", 64'h20, 64'd100);
    rd_chk("lb_beats1", 64'h30, 64'd100);
    rd_chk("lb_cycles0", 64'h28, 64'd100);
    rd_chk("lb_cycles1", 64'h38, 64'd100);
    rd_chk("lb_status", 64'h18, 64'h302);
    // sink-only, channel 0 enabled, 50% random tvalid
    tb_mode = 1; tb_pct = 50;
    axi_write(64'h8, 64'd256);
    axi_write(64'h10, 64'h1);
    tb_drv = 2'b11;
    axi_write(64'h0, 64'h5);
    wait_run(5000);
    tb_drv = '0; step();
    rd_chk("sk_beats0", 64'h20, 64'd256);
    rd_chk("sk_cycles0", 64'h28, 64'(tb_cyc[0]));
    rd_chk("sk_beats1", 64'h30, 64'd0);
    rd_chk("sk_status", 64'h18, status_exp());
    // generator with random backpressure
    tb_mode = 2; tb_rpct = 50;
    for (int c = 0; c < N; c++)
      for (int i = 0; i < 130; i++) sb[c].push_back({gen_last(i, 130), 64'(i)});
    axi_write(64'h8, 64'd130);
    axi_write(64'h10, 64'h3);
    axi_write(64'h0, 64'h9);
    wait_run(5000);
    for (int c = 0; c < N; c++) chk("gen_sb_left", sb[c].size(), 0);
    flush();
    rd_chk("gen_beats0", 64'h20, 64'd130);
    rd_chk("gen_beats1", 64'h30, 64'd130);
    rd_chk("gen_status", 64'h18, 64'h302);
    // partial mask: only channel 1
    tb_mode = 0; tb_rpct = 100; tb_pct = 100;
    axi_write(64'h8, 64'd20);
    axi_write(64'h10, 64'h2);
    tb_drv = 2'b11;
    axi_write(64'h0, 64'h1);
    wait_run(500);
    tb_drv = '0; step(); step(); flush();
    rd_chk("pm_beats0", 64'h20, 64'd0);
    rd_chk("pm_beats1", 64'h30, 64'd20);
    rd_chk("pm_status", 64'h18, 64'h202);
    // CLEAR in the middle of a sink-only run, then a full rerun
    tb_mode = 1; tb_pct = 100;
    axi_write(64'h8, 64'd100);
    axi_write(64'h10, 64'h3);
    tb_drv = 2'b11;
    axi_write(64'h0, 64'h5);
    for (int n = 0; n < 200 && tb_beats[0] < 40; n++) @(negedge clk);
    chk("clr_reached40", tb_beats[0] >= 40, 1);
    axi_write(64'h0, 64'h2);
    rd_chk("clr_beats0", 64'h20, 64'd0);
    rd_chk("clr_cycles1", 64'h38, 64'd0);
    rd_chk("clr_status", 64'h18, 64'h0);
    axi_write(64'h0, 64'h5);
    wait_run(1000);
    tb_drv = '0; step();
    rd_chk("rerun_beats0", 64'h20, 64'd100);
    rd_chk("rerun_cycles0", 64'h28, 64'd100);
    rd_chk("rerun_status", 64'h18, 64'h302);
    // asynchronous reset in the middle of a generator run
    tb_mode = 2; tb_rpct = 100;
    for (int c = 0; c < N; c++)
      for (int i = 0; i < 100; i++) sb[c].push_back({gen_last(i, 100), 64'(i)});
    axi_write(64'h8, 64'd100);
    axi_write(64'h10, 64'h3);
    axi_write(64'h0, 64'h9);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    tb_act = '0; tb_state = 0; tb_len = '0; tb_en = '0; zero_model();
    #1;
    chk("arst_src_tvalid", sr_valid, 0);
    chk("arst_sink_tready", sk_ready, 0);
    chk("arst_arready", arready, 0);
    flush();
    @(negedge clk);
    rst = 1'b0;
    rd_chk("arst_len", 64'h8, 64'h0);
    rd_chk("arst_en", 64'h10, 64'h0);
    rd_chk("arst_beats0", 64'h20, 64'h0);
    rd_chk("arst_status", 64'h18, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
